// File: rtl/lattice_pkg.sv
// Shared types and helpers for the 8x8 LED lattice scan controller.
package lattice_pkg;

  localparam int ROWS_N  = 8;
  localparam int COLS_N  = 8;
  localparam int FRAME_W = 64;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Byte r of the frame holds the column bits of row r.
  function automatic logic [COLS_N-1:0] row_byte(input logic [FRAME_W-1:0] frame,
                                                 input logic [2:0] row);
    return frame[row*COLS_N +: COLS_N];
  endfunction

endpackage

// File: rtl/lattice_frame_buf.sv
// Double frame buffer: pending register filled by the source, active register
// loaded from pending only when the scanner signals a frame boundary.
module lattice_frame_buf
  import lattice_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [FRAME_W-1:0] FRAME_DATA,
  input  logic               FRAME_VALID,
  output logic               FRAME_READY,
  input  logic               SWAP,
  output logic [FRAME_W-1:0] ACTIVE
);

  logic [FRAME_W-1:0] pending_q;
  logic               pending_full_q;
  logic               pending_full_d;
  logic               accept;
  logic               do_swap;

  // A frame transfers on a rising CLK edge where FRAME_VALID and FRAME_READY
  // are both high; FRAME_READY is registered (~pending_full) and the source
  // must hold FRAME_DATA stable while FRAME_VALID is high and READY is low.
  assign accept  = FRAME_VALID & FRAME_READY;
  assign do_swap = SWAP & pending_full_q;

  always_comb begin
    pending_full_d = pending_full_q;
    if (do_swap) begin
      pending_full_d = 1'b0;
    end else if (accept) begin
      pending_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      FRAME_READY    <= 1'b0;
      ACTIVE         <= '0;
    end else begin
      pending_full_q <= pending_full_d;
      FRAME_READY    <= ~pending_full_d;
      if (accept) begin
        pending_q <= FRAME_DATA;
      end
      if (do_swap) begin
        ACTIVE <= pending_q;
      end
    end
  end

endmodule

// File: rtl/lattice_scan_ctrl.sv
// Row-multiplexed scanner for an 8x8 LED lattice with tear-free frame swaps.
// Optional macro LATTICE_PWM_EN adds BRIGHTNESS[2:0] column duty control.
module lattice_scan_ctrl
  import lattice_pkg::*;
#(
  parameter int   DWELL_TICKS = 8,
  parameter int   BLANK_TICKS = 1,
  parameter logic ROW_POL     = 1'b1,
  parameter logic COL_POL     = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               TICK,
  input  logic [FRAME_W-1:0] FRAME_DATA,
  input  logic               FRAME_VALID,
  output logic               FRAME_READY,
  input  logic               OE,
`ifdef LATTICE_PWM_EN
  input  logic [2:0]         BRIGHTNESS,
`endif
  output logic [ROWS_N-1:0]  ROWS,
  output logic [COLS_N-1:0]  COLUMNS,
  output logic               FRAME_START,
  output logic [3:0]         DBG_STATE
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);
  localparam logic [7:0] BLANK_LAST = (BLANK_TICKS == 0) ? 8'd0 : 8'(BLANK_TICKS - 1);
  localparam bit         NO_BLANK   = (BLANK_TICKS == 0);

  scan_state_t        state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               boundary, boundary_q;
  logic [FRAME_W-1:0] active;
  logic               col_on;
  logic               lit;
  logic [ROWS_N-1:0]  row_sel;
  logic [COLS_N-1:0]  col_bits;
  logic [ROWS_N-1:0]  rows_d;
  logic [COLS_N-1:0]  cols_d;

  lattice_frame_buf u_frame_buf (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .FRAME_DATA  (FRAME_DATA),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_READY (FRAME_READY),
    .SWAP        (boundary),
    .ACTIVE      (active)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_BLANK;
      row_q      <= 3'd0;
      cnt_q      <= 8'd0;
      boundary_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      boundary_q <= boundary;
    end
  end

  // In BLANK, row_q already names the row that will be shown next.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (TICK) begin
      if (state_q == ST_SHOW) begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = 8'd0;
          row_d = row_q + 3'd1;
          if (NO_BLANK) begin
            boundary = (row_q == 3'd7);
          end else begin
            state_d = ST_BLANK;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d    = 8'd0;
          state_d  = ST_SHOW;
          boundary = (row_q == 3'd0);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

`ifdef LATTICE_PWM_EN
  logic [2:0] bright_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bright_q <= 3'd7;
    end else if (boundary) begin
      bright_q <= BRIGHTNESS;
    end
  end

  assign col_on = ({1'b0, cnt_q, 3'b000}) < ((12'(bright_q) + 12'd1) * 12'(DWELL_TICKS));
`else
  assign col_on = 1'b1;
`endif

  always_comb begin
    lit      = (state_q == ST_SHOW) & OE;
    row_sel  = 8'b1 << row_q;
    col_bits = row_byte(active, row_q);
    rows_d   = {ROWS_N{~ROW_POL}};
    cols_d   = {COLS_N{~COL_POL}};
    if (lit) begin
      rows_d = ROW_POL ? row_sel : ~row_sel;
      if (col_on) begin
        cols_d = COL_POL ? col_bits : ~col_bits;
      end
    end
  end

  // Pins lag the scan state by one cycle so they come straight from flops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ROWS        <= {ROWS_N{~ROW_POL}};
      COLUMNS     <= {COLS_N{~COL_POL}};
      FRAME_START <= 1'b0;
    end else begin
      ROWS        <= rows_d;
      COLUMNS     <= cols_d;
      FRAME_START <= boundary_q;
    end
  end

  assign DBG_STATE = {state_q, row_q};

endmodule
